// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller: MUL/DIV FSM state,
// forwarding-stage indices and the operand-select encoding.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam int STG_M = 0;
    localparam int STG_W = 1;

    // Younger producers get larger codes; code 0 selects the register file.
    function automatic int fsel_code(input int stage, input int fwd_stages);
        return fwd_stages - stage;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Forwarding priority search for one E-stage source operand: the youngest
// writing producer whose destination matches a non-zero source wins.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int FWD_STAGES = 2,
    parameter int FSEL_W     = 2
) (
    input  logic [RA_W-1:0]            rs_i,
    input  logic [FWD_STAGES*RA_W-1:0] rd_stg_i,
    input  logic [FWD_STAGES-1:0]      reg_wr_i,
    output logic [FSEL_W-1:0]          fsel_o
);

    always_comb begin
        // NOTE: default assignment first so no path leaves fsel_o unassigned (no latch).
        fsel_o = '0;
        // Scan oldest to youngest so the lowest matching stage is written last.
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (reg_wr_i[k] && (rs_i != '0) && (rd_stg_i[k*RA_W +: RA_W] == rs_i)) begin
                fsel_o = FSEL_W'(fsel_code(k, FWD_STAGES));
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: RAW forwarding selects, load-use stall, branch flush,
// multi-cycle MUL/DIV occupancy FSM and saturating stall/flush counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32,
    localparam int FSEL_W    = $clog2(FWD_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC*RA_W-1:0]      RsD,
    input  logic [NUM_SRC*RA_W-1:0]      RsE,
    input  logic [RA_W-1:0]              RdE,
    input  logic                         MemReadE,
    input  logic                         PCSrcE,
    input  logic                         MdStartE,
    input  logic [FWD_STAGES*RA_W-1:0]   RdStg,
    input  logic [FWD_STAGES-1:0]        RegWrStg,
    input  logic                         CntClr,
    output logic [NUM_SRC*FSEL_W-1:0]    ForwardE,
    output logic                         StallF,
    output logic                         StallD,
    output logic                         StallE,
    output logic                         FlushD,
    output logic                         FlushE,
    output logic                         FlushM,
    output logic                         MdDone,
    output logic [CNT_W-1:0]             StallCnt,
    output logic [CNT_W-1:0]             FlushCnt
);

    localparam int MDC_W    = $clog2(MD_LATENCY + 1);
    localparam bit MD_MULTI = (MD_LATENCY > 1);

    md_state_e        state_q, state_d;
    logic [MDC_W-1:0] mdc_q, mdc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             md_go, md_stall, lu_hit, lu, br;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_select #(
            .RA_W       (RA_W),
            .FWD_STAGES (FWD_STAGES),
            .FSEL_W     (FSEL_W)
        ) u_fwd_select (
            .rs_i     (RsE[i*RA_W +: RA_W]),
            .rd_stg_i (RdStg),
            .reg_wr_i (RegWrStg),
            .fsel_o   (ForwardE[i*FSEL_W +: FSEL_W])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mdc_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            mdc_q   <= mdc_d;
        end
    end

    assign md_go = MD_MULTI && (state_q == IDLE) && MdStartE;

    always_comb begin
        state_d = state_q;
        mdc_d   = mdc_q;
        case (state_q)
            IDLE: if (md_go) begin
                state_d = BUSY;
                mdc_d   = MDC_W'(MD_LATENCY - 1);
            end
            BUSY: begin
                mdc_d = mdc_q - MDC_W'(1);
                if (mdc_q <= MDC_W'(1)) begin
                    state_d = IDLE;
                    mdc_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lu_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (RsD[i*RA_W +: RA_W] == RdE) lu_hit = 1'b1;
        end
    end

    // An occupied E stage overrides load-use and branch; branch overrides load-use.
    always_comb begin
        md_stall = md_go || ((state_q == BUSY) && (mdc_q > MDC_W'(1)));
        lu       = MemReadE && (RdE != '0) && lu_hit && !PCSrcE && !md_stall;
        br       = PCSrcE && !md_stall;
        StallF   = md_stall || lu;
        StallD   = md_stall || lu;
        StallE   = md_stall;
        FlushD   = br;
        FlushE   = br || lu;
        FlushM   = md_stall;
        MdDone   = ((state_q == BUSY) && (mdc_q == MDC_W'(1)))
                || (!MD_MULTI && (state_q == IDLE) && MdStartE);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CntClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if ((FlushD || FlushE) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: default hazard_ctrl_unit plus a narrow-counter, single-cycle
// MUL/DIV instance sharing the same stimulus.
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rs_d, rs_e, rd_stg;
    logic [4:0]  rd_e;
    logic        mem_read_e, pc_src_e, md_start_e, cnt_clr;
    logic [1:0]  reg_wr_stg;

    logic [3:0]  fwd_e;
    logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_done;
    logic [31:0] stall_cnt, flush_cnt;

    logic [3:0]  s_fwd_e;
    logic        s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_flush_m, s_md_done;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit u_dut (
        .clk(clk), .rst(rst), .RsD(rs_d), .RsE(rs_e), .RdE(rd_e),
        .MemReadE(mem_read_e), .PCSrcE(pc_src_e), .MdStartE(md_start_e),
        .RdStg(rd_stg), .RegWrStg(reg_wr_stg), .CntClr(cnt_clr),
        .ForwardE(fwd_e), .StallF(stall_f), .StallD(stall_d), .StallE(stall_e),
        .FlushD(flush_d), .FlushE(flush_e), .FlushM(flush_m), .MdDone(md_done),
        .StallCnt(stall_cnt), .FlushCnt(flush_cnt)
    );

    hazard_ctrl_unit #(.MD_LATENCY(1), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .RsD(rs_d), .RsE(rs_e), .RdE(rd_e),
        .MemReadE(mem_read_e), .PCSrcE(pc_src_e), .MdStartE(md_start_e),
        .RdStg(rd_stg), .RegWrStg(reg_wr_stg), .CntClr(cnt_clr),
        .ForwardE(s_fwd_e), .StallF(s_stall_f), .StallD(s_stall_d), .StallE(s_stall_e),
        .FlushD(s_flush_d), .FlushE(s_flush_e), .FlushM(s_flush_m), .MdDone(s_md_done),
        .StallCnt(s_stall_cnt), .FlushCnt(s_flush_cnt)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        rs_d = '0; rs_e = '0; rd_stg = '0; rd_e = '0; reg_wr_stg = '0;
        mem_read_e = 1'b0; pc_src_e = 1'b0; md_start_e = 1'b0; cnt_clr = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk1("rst_stall_f", stall_f, 1'b0);
        chk1("rst_stall_e", stall_e, 1'b0);
        chk1("rst_flush_e", flush_e, 1'b0);
        chk1("rst_flush_m", flush_m, 1'b0);
        chk1("rst_md_done", md_done, 1'b0);
        chk32("rst_stall_cnt", stall_cnt, 32'd0);
        chk32("rst_flush_cnt", flush_cnt, 32'd0);
        chk4("rst_fwd", fwd_e, 4'b0000);

        @(negedge clk); rst = 1'b1;

        // Forwarding: M beats W, then W alone, then x0 never forwards, then mixed.
        @(negedge clk);
        rs_e = {5'd0, 5'd5}; rd_stg = {5'd5, 5'd5}; reg_wr_stg = 2'b11;
        #1 chk4("fwd_m_wins", fwd_e, 4'b0010);
        reg_wr_stg = 2'b10;
        #1 chk4("fwd_w_only", fwd_e, 4'b0001);

        @(negedge clk);
        rs_e = {5'd0, 5'd5}; rd_stg = {5'd0, 5'd0}; reg_wr_stg = 2'b01;
        #1 chk4("fwd_x0", fwd_e, 4'b0000);
        rs_e = {5'd9, 5'd3}; rd_stg = {5'd3, 5'd9}; reg_wr_stg = 2'b11;
        #1 chk4("fwd_mixed", fwd_e, 4'b1001);
        chk1("fwd_no_stall", stall_f, 1'b0);

        // Load-use stall, then load-use masked by a taken branch.
        @(negedge clk);
        rs_e = '0; rd_stg = '0; reg_wr_stg = '0;
        mem_read_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
        #1;
        chk1("lu_stall_f", stall_f, 1'b1);
        chk1("lu_stall_d", stall_d, 1'b1);
        chk1("lu_flush_e", flush_e, 1'b1);
        chk1("lu_flush_d", flush_d, 1'b0);
        chk1("lu_stall_e", stall_e, 1'b0);

        @(negedge clk); mem_read_e = 1'b0;
        #1;
        chk1("lu_over", stall_f, 1'b0);
        chk32("lu_stall_cnt", stall_cnt, 32'd1);
        chk32("lu_flush_cnt", flush_cnt, 32'd1);
        chk32("lu_small_cnt", 32'(s_stall_cnt), 32'd1);

        @(negedge clk); mem_read_e = 1'b1; pc_src_e = 1'b1;
        #1;
        chk1("br_stall_f", stall_f, 1'b0);
        chk1("br_flush_d", flush_d, 1'b1);
        chk1("br_flush_e", flush_e, 1'b1);

        @(negedge clk); pc_src_e = 1'b0; rd_e = 5'd0; rs_d = '0;
        #1;
        chk1("lu_rd0", stall_f, 1'b0);
        chk1("lu_rd0_flush", flush_e, 1'b0);
        chk32("br_stall_cnt", stall_cnt, 32'd1);
        chk32("br_flush_cnt", flush_cnt, 32'd2);

        // MUL/DIV occupancy: three stall cycles then MdDone.
        @(negedge clk); mem_read_e = 1'b0; md_start_e = 1'b1;
        #1;
        chk1("md1_stall_f", stall_f, 1'b1);
        chk1("md1_stall_d", stall_d, 1'b1);
        chk1("md1_stall_e", stall_e, 1'b1);
        chk1("md1_flush_m", flush_m, 1'b1);
        chk1("md1_flush_e", flush_e, 1'b0);
        chk1("md1_done", md_done, 1'b0);
        chk1("md_lat1_done", s_md_done, 1'b1);
        chk1("md_lat1_stall", s_stall_e, 1'b0);
        @(negedge clk); #1;
        chk1("md2_stall_e", stall_e, 1'b1);
        chk1("md2_done", md_done, 1'b0);
        @(negedge clk); #1;
        chk1("md3_stall_e", stall_e, 1'b1);
        chk1("md3_done", md_done, 1'b0);
        @(negedge clk); #1;
        chk1("md4_stall_e", stall_e, 1'b0);
        chk1("md4_stall_f", stall_f, 1'b0);
        chk1("md4_flush_m", flush_m, 1'b0);
        chk1("md4_done", md_done, 1'b1);
        chk32("md_stall_cnt", stall_cnt, 32'd4);

        // Back-to-back restart, then reset while BUSY.
        @(negedge clk); #1;
        chk1("md_b2b_stall", stall_e, 1'b1);
        chk1("md_b2b_done", md_done, 1'b0);
        @(negedge clk); #1;
        chk32("md_b2b_cnt", stall_cnt, 32'd5);
        chk1("md_b2b_busy", stall_e, 1'b1);
        rst = 1'b0; md_start_e = 1'b0;
        #1;
        chk1("rstmd_stall_e", stall_e, 1'b0);
        chk1("rstmd_stall_f", stall_f, 1'b0);
        chk1("rstmd_done", md_done, 1'b0);
        chk32("rstmd_cnt", stall_cnt, 32'd0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk1("rstmd_no_done", md_done, 1'b0);
            chk1("rstmd_idle", stall_e, 1'b0);
        end

        // CntClr wins over a stalling cycle.
        @(negedge clk); md_start_e = 1'b1;
        #1 chk1("clr_stall", stall_e, 1'b1);
        @(negedge clk); #1;
        chk32("clr_pre", stall_cnt, 32'd1);
        cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        #1;
        chk32("clr_wins", stall_cnt, 32'd0);
        chk1("clr_still_stall", stall_e, 1'b1);
        @(negedge clk); #1;
        chk1("clr_md_done", md_done, 1'b1);
        chk32("clr_post", stall_cnt, 32'd1);

        // Saturation on the 2-bit counters of the narrow instance.
        @(negedge clk); md_start_e = 1'b0;
        mem_read_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk32("sat_ramp", 32'(s_stall_cnt), (i < 3) ? i : 3);
            chk1("sat_stall_f", stall_f, 1'b1);
        end
        @(negedge clk); mem_read_e = 1'b0;
        #1;
        chk32("sat_stall_hold", 32'(s_stall_cnt), 32'd3);
        chk32("sat_flush_hold", 32'(s_flush_cnt), 32'd3);
        chk32("sat_main_stall", stall_cnt, 32'd6);
        chk32("sat_main_flush", flush_cnt, 32'd5);

        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        #1;
        chk32("sat_clr_small", 32'(s_stall_cnt), 32'd0);
        chk32("sat_clr_main", stall_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
